// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and helpers for the shared serial-multiplier
// scheduler.
//   state_t    : scheduler state (IDLE / RUN / DONE)
//   clog2      : ceiling log2 of a positive integer
//   idx_w      : index width for n items, never less than 1 bit
//   sat_clamp  : clamps a 64-bit product to an ow-bit signed or unsigned range
package mult_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    // The caller extends the product to 64 bits (sign- or zero-extended to
    // match sgn), so one comparison against the limits covers both modes.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input logic              sgn,
                                                     input int                ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        if (sgn) begin
            hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (ow - 1));
        end else begin
            hi = (64'sd1 <<< ow) - 64'sd1;
            lo = 64'sd0;
        end
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/mult_sched_mult.sv
// mult_serial: serial shift-add multiplier, one partial product per cycle.
//   clk, reset_n : clock, synchronous active-low reset (clears busy/count)
//   load         : capture a, b, sgn and start a W-step multiply
//   a, b, sgn    : operands; sgn=1 treats them as two's complement
//   busy         : an operation is in progress
//   valid        : this cycle performs the final step; prod is the result
//   prod         : full 2W-bit product (sign applied), meaningful with valid
module mult_serial
    import mult_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sgn,
    output logic             busy,
    output logic             valid,
    output logic [2*W-1:0]   prod
);

    localparam int CW = idx_w(W);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   a_mag, b_mag;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;

    always_comb begin
        // Magnitudes fit in W unsigned bits; the most negative value maps
        // to 2^(W-1).
        a_mag    = (sgn && a[W-1]) ? (~a + 1'b1) : a;
        b_mag    = (sgn && b[W-1]) ? (~b + 1'b1) : b;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;

        if (load) begin
            mcand_d  = {{W{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
            cnt_d    = CW'(W - 1);
            neg_d    = sgn && (a[W-1] ^ b[W-1]);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        neg_q    <= neg_d;
    end

    // The result is presented during the final step so the scheduler can
    // register it on the same edge that ends the run.
    assign busy  = busy_q;
    assign valid = busy_q && (cnt_q == '0);
    assign prod  = neg_q ? (~acc_sum + 1'b1) : acc_sum;

endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler sharing one serial multiplier among
// N_REQ requesters.
//   clk, reset_n     : clock, synchronous active-low reset
//   req              : level request per requester
//   a_flat, b_flat   : operands, requester i at [i*W +: W]
//   sgn              : per-requester two's complement flag
//   grant            : one-hot pulse when the winner's operands are captured
//   running          : high from capture through the done cycle
//   done, done_id    : one-hot completion pulse and winner index
//   prod, prod_sat   : full product and OW-bit saturated copy (held)
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int W     = 4,
    parameter  int OW    = 6,
    localparam int IDW   = idx_w(N_REQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_flat,
    input  logic [N_REQ*W-1:0] b_flat,
    input  logic [N_REQ-1:0]   sgn,
    output logic [N_REQ-1:0]   grant,
    output logic               running,
    output logic [N_REQ-1:0]   done,
    output logic [IDW-1:0]     done_id,
    output logic [2*W-1:0]     prod,
    output logic [OW-1:0]      prod_sat
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     win_q, win_d;
    logic               sgn_q, sgn_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic               running_q, running_d;
    logic [2*W-1:0]     prod_q, prod_d;
    logic [OW-1:0]      prod_sat_q, prod_sat_d;

    logic [W-1:0]       a_arr [N_REQ];
    logic [W-1:0]       b_arr [N_REQ];
    logic [IDW-1:0]     rr_win;
    logic               rr_found;
    logic [IDW:0]       rr_idx;
    logic [IDW-1:0]     ptr_nxt;
    logic               mul_load;
    logic               mul_busy;
    logic               mul_valid;
    logic [2*W-1:0]     mul_prod;
    logic signed [63:0] sat_in;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = a_flat[g*W +: W];
        assign b_arr[g] = b_flat[g*W +: W];
    end

    // First set request at or above ptr, wrapping past N_REQ-1 back to 0.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (rr_idx >= (IDW+1)'(N_REQ)) begin
                rr_idx = rr_idx - (IDW+1)'(N_REQ);
            end
            if (!rr_found && req[rr_idx[IDW-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx[IDW-1:0];
            end
        end
        ptr_nxt = (rr_win == IDW'(N_REQ - 1)) ? '0 : rr_win + 1'b1;
    end

    mult_serial #(.W(W)) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .a       (a_arr[rr_win]),
        .b       (b_arr[rr_win]),
        .sgn     (sgn[rr_win]),
        .busy    (mul_busy),
        .valid   (mul_valid),
        .prod    (mul_prod)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        sgn_d      = sgn_q;
        grant_d    = '0;
        done_d     = '0;
        done_id_d  = done_id_q;
        running_d  = running_q;
        prod_d     = prod_q;
        prod_sat_d = prod_sat_q;
        mul_load   = 1'b0;

        sat_in = sgn_q ? 64'(signed'(mul_prod)) : 64'(mul_prod);

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    mul_load         = 1'b1;
                    win_d            = rr_win;
                    sgn_d            = sgn[rr_win];
                    grant_d[rr_win]  = 1'b1;
                    running_d        = 1'b1;
                    ptr_d            = ptr_nxt;
                    state_d          = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mul_valid) begin
                    done_d[win_q] = 1'b1;
                    done_id_d     = win_q;
                    prod_d        = mul_prod;
                    prod_sat_d    = OW'(sat_clamp(sat_in, sgn_q, OW));
                    state_d       = ST_DONE;
                end else if (!mul_busy) begin
                    // Multiplier has no operation in flight; drop back
                    // rather than wait forever.
                    running_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: begin
                running_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                running_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            win_q      <= '0;
            sgn_q      <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            done_id_q  <= '0;
            running_q  <= 1'b0;
            prod_q     <= '0;
            prod_sat_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            sgn_q      <= sgn_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            done_id_q  <= done_id_d;
            running_q  <= running_d;
            prod_q     <= prod_d;
            prod_sat_q <= prod_sat_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign done_id  = done_id_q;
    assign running  = running_q;
    assign prod     = prod_q;
    assign prod_sat = prod_sat_q;

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: directed bench for mult_sched with a behavioural reference
// model checked every cycle plus literal expectations for key vectors.
module tb_mult_sched;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int OW  = 6;
    localparam int IDW = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     a_flat;
    logic [N*W-1:0]     b_flat;
    logic [N-1:0]       sgn;
    logic [N-1:0]       grant;
    logic               running;
    logic [N-1:0]       done;
    logic [IDW-1:0]     done_id;
    logic [2*W-1:0]     prod;
    logic [OW-1:0]      prod_sat;

    mult_sched #(.N_REQ(N), .W(W), .OW(OW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .a_flat   (a_flat),
        .b_flat   (b_flat),
        .sgn      (sgn),
        .grant    (grant),
        .running  (running),
        .done     (done),
        .done_id  (done_id),
        .prod     (prod),
        .prod_sat (prod_sat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endfunction

    function automatic bit hit(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    // Reference product: plain integer arithmetic on the operand values.
    function automatic void ref_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                     output logic [2*W-1:0] p, output logic [OW-1:0] sat);
        int av, bv, pr, cl;
        logic [31:0] pv;
        av = 32'(a);
        bv = 32'(b);
        if (s && av >= (1 << (W-1))) av = av - (1 << W);
        if (s && bv >= (1 << (W-1))) bv = bv - (1 << W);
        pr = av * bv;
        pv = pr;
        p  = pv[2*W-1:0];
        cl = pr;
        if (s) begin
            if (cl > (1 << (OW-1)) - 1) cl = (1 << (OW-1)) - 1;
            if (cl < -(1 << (OW-1)))    cl = -(1 << (OW-1));
        end else if (cl > (1 << OW) - 1) begin
            cl = (1 << OW) - 1;
        end
        pv  = cl;
        sat = pv[OW-1:0];
    endfunction

    // Reference model: a grant lands one cycle after an idle arbitration,
    // done W cycles after that, and arbitration resumes W+2 cycles after it.
    logic [N-1:0]   e_grant, e_done;
    logic           e_running;
    logic [IDW-1:0] e_id;
    logic [2*W-1:0] e_prod, pend_p;
    logic [OW-1:0]  e_sat, pend_s;
    int m_ptr, m_cnt, m_win;

    initial begin
        m_ptr = 0; m_cnt = -1; m_win = 0;
        e_grant = '0; e_done = '0; e_running = 1'b0; e_id = '0;
        e_prod = '0; e_sat = '0; pend_p = '0; pend_s = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_ptr = 0; m_cnt = -1;
                e_grant = '0; e_done = '0; e_running = 1'b0; e_id = '0;
                e_prod = '0; e_sat = '0;
            end else begin
                e_grant = '0;
                e_done  = '0;
                if (m_cnt < 0) begin
                    if (req != '0) begin
                        bit found;
                        found = 1'b0;
                        for (int k = 0; k < N; k++) begin
                            if (!found && hit(req, (m_ptr + k) % N)) begin
                                found = 1'b1;
                                m_win = (m_ptr + k) % N;
                            end
                        end
                        e_grant   = N'(1) << m_win;
                        e_running = 1'b1;
                        m_ptr     = (m_win + 1) % N;
                        m_cnt     = 0;
                        ref_mult(W'(a_flat >> (m_win*W)), W'(b_flat >> (m_win*W)),
                                 hit(sgn, m_win), pend_p, pend_s);
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == W) begin
                        e_done = N'(1) << m_win;
                        e_id   = IDW'(m_win);
                        e_prod = pend_p;
                        e_sat  = pend_s;
                    end else if (m_cnt == W + 1) begin
                        e_running = 1'b0;
                        m_cnt     = -1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("grant",    32'(grant),    32'(e_grant));
                chk("done",     32'(done),     32'(e_done));
                chk("running",  32'(running),  32'(e_running));
                chk("prod",     32'(prod),     32'(e_prod));
                chk("prod_sat", 32'(prod_sat), 32'(e_sat));
                if (e_done != '0) chk("done_id", 32'(done_id), 32'(e_id));
            end
        end
    end

    task automatic set_ops(input int idx, input int a, input int b, input bit s);
        logic [N*W-1:0] m;
        m      = {{(N*W-W){1'b0}}, {W{1'b1}}} << (idx*W);
        a_flat = (a_flat & ~m) | (((N*W)'(a)) << (idx*W) & m);
        b_flat = (b_flat & ~m) | (((N*W)'(b)) << (idx*W) & m);
        sgn    = s ? (sgn | (N'(1) << idx)) : (sgn & ~(N'(1) << idx));
    endtask

    task automatic set_req(input int idx, input bit v);
        req = v ? (req | (N'(1) << idx)) : (req & ~(N'(1) << idx));
    endtask

    task automatic wait_grant(output int w);
        bit got;
        got = 1'b0;
        w   = -1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (hit(grant, i)) begin w = i; got = 1'b1; end
        end
        if (!got) timeout_fail("wait_grant");
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (!running) got = 1'b1;
        end
        if (!got) timeout_fail("wait_idle");
    endtask

    task automatic do_op(input int idx, input int a, input int b, input bit s,
                         output int gcyc, output int dcyc, output logic [N-1:0] gvec);
        bit got;
        @(negedge clk);
        set_ops(idx, a, b, s);
        set_req(idx, 1'b1);
        gcyc = 0; gvec = '0; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            gcyc++;
            if (hit(grant, idx)) begin gvec = grant; got = 1'b1; end
        end
        if (!got) timeout_fail("op_grant");
        set_req(idx, 1'b0);
        dcyc = gcyc; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            dcyc++;
            if (hit(done, idx)) got = 1'b1;
        end
        if (!got) timeout_fail("op_done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, d, w, ngr, cnt;
        int ord[4];
        int tgr[4];
        logic [N-1:0] gv;

        reset_n = 1'b0; req = '0; a_flat = '0; b_flat = '0; sgn = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_grant",   32'(grant),    0);
        chk("rst_done",    32'(done),     0);
        chk("rst_running", 32'(running),  0);
        chk("rst_prod",    32'(prod),     0);
        chk("rst_sat",     32'(prod_sat), 0);
        chk("rst_done_id", 32'(done_id),  0);
        reset_n = 1'b1;

        // Unsigned 15*15 on requester 1.
        do_op(1, 15, 15, 1'b0, g, d, gv);
        chk("t1_grant_lat", g, 1);
        chk("t1_grant_vec", 32'(gv), 32'h2);
        chk("t1_done_lat",  d, W + 1);
        chk("t1_done_vec",  32'(done), 32'h2);
        chk("t1_done_id",   32'(done_id), 1);
        chk("t1_prod",      32'(prod), 225);
        chk("t1_sat",       32'(prod_sat), 63);

        // Signed vectors on requester 2 (8-bit / 6-bit encodings).
        do_op(2, -8, -8, 1'b1, g, d, gv);
        chk("t2a_prod", 32'(prod), 64);
        chk("t2a_sat",  32'(prod_sat), 31);
        do_op(2, -8, 7, 1'b1, g, d, gv);
        chk("t2b_prod", 32'(prod), 200);   // -56
        chk("t2b_sat",  32'(prod_sat), 32); // -32
        do_op(2, 3, -2, 1'b1, g, d, gv);
        chk("t2c_prod", 32'(prod), 250);   // -6
        chk("t2c_sat",  32'(prod_sat), 58); // -6

        // All four requesting straight out of reset.
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        a_flat = 16'h3A5C; b_flat = 16'h7F21; sgn = 4'b0101; req = 4'b1111;
        ngr = 0;
        for (int c = 0; c < 100 && ngr < 4; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                for (int i = 0; i < N; i++) if (hit(grant, i)) ord[ngr] = i;
                tgr[ngr] = c;
                set_req(ord[ngr], 1'b0);
                ngr++;
            end
        end
        if (ngr < 4) timeout_fail("arb_all");
        for (int i = 0; i < ngr; i++) chk("arb_order", ord[i], i);
        for (int i = 1; i < ngr; i++) chk("arb_spacing", tgr[i] - tgr[i-1], W + 2);
        wait_idle();

        // Pointer decides between requesters 0 and 3.
        @(negedge clk);
        set_req(0, 1'b1); set_req(3, 1'b1);
        wait_grant(w); chk("pair_ptr0", w, 0); set_req(0, 1'b0);
        repeat (2) @(negedge clk);
        set_req(0, 1'b1);
        wait_grant(w); chk("pair_ptr1", w, 3); set_req(3, 1'b0);
        wait_grant(w); chk("pair_wrap", w, 0); set_req(0, 1'b0);
        wait_idle();

        // Reset two cycles into a run.
        @(negedge clk);
        set_ops(2, 6, 5, 1'b0); set_req(2, 1'b1);
        wait_grant(w); set_req(2, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mrst_prod",    32'(prod), 0);
        chk("mrst_sat",     32'(prod_sat), 0);
        chk("mrst_running", 32'(running), 0);
        chk("mrst_done_id", 32'(done_id), 0);
        cnt = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (done != '0) cnt++;
        end
        chk("mrst_no_done", cnt, 0);
        set_req(1, 1'b1); set_req(3, 1'b1);
        wait_grant(w); chk("mrst_ptr", w, 1); set_req(1, 1'b0);
        wait_grant(w); chk("mrst_next", w, 3); set_req(3, 1'b0);
        wait_idle();
        do_op(2, 6, 5, 1'b0, g, d, gv);
        chk("mrst_op_prod", 32'(prod), 30);
        chk("mrst_op_sat",  32'(prod_sat), 30);

        // Every operand pair on requester 3, both signedness modes.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    do_op(3, a, b, s[0], g, d, gv);

        // Request raised and dropped while the multiplier is busy.
        @(negedge clk);
        set_ops(0, 2, 3, 1'b0); set_req(0, 1'b1);
        wait_grant(w); set_req(0, 1'b0);
        repeat (2) @(negedge clk);
        set_req(1, 1'b1);
        repeat (2) @(negedge clk);
        set_req(1, 1'b0);
        cnt = 0;
        for (int c = 0; c < W + 6; c++) begin
            @(negedge clk);
            if (hit(grant, 1)) cnt++;
        end
        chk("ignored_req", cnt, 0);
        chk("ignored_prod", 32'(prod), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that shares one serial shift-add multiplier between `N_REQ` requesters. Each requester posts two `W`-bit operands and a signedness flag. The block arbitrates, runs the multiply over `W` cycles, and returns the full-precision product plus an `OW`-bit saturated copy with a one-cycle done pulse to the winner. It sits between client sequencers and the shared multiply datapath, which they would otherwise each instantiate.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 4, operand width
- `OW`, 6, saturated-output width (`OW` < 2·`W`)
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: synchronous, active-low reset
- `req` in `N_REQ`: level request, one bit per requester
- `a_flat` in `N_REQ`·`W`: operand A, requester i at bits [i·W +: W]
- `b_flat` in `N_REQ`·`W`: operand B, same packing as A
- `sgn` in `N_REQ`: 1 = operands are two's complement for requester i
- `grant` out `N_REQ`: one-hot, one-cycle pulse when requester i's operands are captured
- `running` out 1: high from capture through the done cycle
- `done` out `N_REQ`: one-hot, one-cycle pulse when `prod`/`prod_sat` are valid for requester i
- `done_id` out clog2(`N_REQ`): index of the requester being completed; valid with `done`
- `prod` out 2·`W`: full product, signed or unsigned per captured `sgn`
- `prod_sat` out `OW`: product clamped to `OW` bits

## Operation
- States: IDLE → RUN → DONE → IDLE.
- **IDLE:**
  - If any `req` is high, select the winner by round-robin from pointer `ptr`: the first set bit at or above `ptr`, wrapping around.
  - At the edge, capture that requester's `a`, `b` and `sgn`. Set `grant[win]` and `running`, load the count with `W`-1, go to RUN.
  - Set `ptr` = (win+1) mod `N_REQ`.
- **RUN:**
  - One shift-add step per cycle on magnitudes: |a| is the multiplicand, |b| is the multiplier.
  - Signed case: the magnitude of the most negative value is 2^(W-1), held in `W` bits unsigned.
  - When the count reaches 0, go to DONE.
- **DONE:**
  - Drive `done[win]`, `done_id` and `prod`. The product is negated when `sgn` is set and the operand signs differ.
  - Drive `prod_sat`:
    - Unsigned: min(prod, 2^OW-1).
    - Signed: clamp to [-2^(OW-1), 2^(OW-1)-1].
  - Return to IDLE next cycle.
- **Outputs and hold:**
  - `prod`/`prod_sat` hold their value until the next DONE.
  - `grant` and `done` are zero in every other cycle.
- **Requester rule:** hold `req` and operands stable until `grant`, then deassert `req`. A `req` still high when IDLE is re-entered is a new request.
- **No back-to-back work:** `req` changes during RUN/DONE are ignored; arbitration happens only in IDLE.
- **`N_REQ` = 1:** the round-robin degenerates to always granting requester 0.

## Timing
- `req` first sampled high at edge k:
  - `grant` high in cycle k+1.
  - `done` high in cycle k+1+`W`.
  - IDLE again at cycle k+2+`W`.
- Minimum spacing between grants is `W`+2 cycles.
- Reset values, applied while `reset_n`=0 at an edge: state IDLE, `ptr`=0, `grant`=0, `done`=0, `done_id`=0, `running`=0, `prod`=0, `prod_sat`=0.
- Reset mid-RUN or mid-DONE discards the operation. No `done` is issued for it, and `ptr` returns to 0.
- Simultaneous requests are resolved only by `ptr`; there is no fixed priority.

## Structure
- `mult_sched_pkg`:
  - state enum (IDLE/RUN/DONE)
  - clog2 helper function
  - saturation function `sat_clamp(value, sgn)` parameterised on `OW`
- Sub-module `mult_serial`:
  - Ports: `clk`, `reset_n`, `load`, `a`, `b`, `sgn`, `busy`, `valid`, `prod`.
  - Holds magnitude conversion, the shift-add accumulator, the count and the final negate.
  - `mult_sched` itself holds only the arbiter, state machine and saturation.

## Test plan
- Only `req[1]`, unsigned, a=15, b=15:
  - `grant`=0010 one cycle after request.
  - `done`=0010 and `done_id`=1 exactly `W` cycles later.
  - `prod`=225, `prod_sat`=63.
- Only `req[2]`, signed:
  - a=-8, b=-8 → `prod`=64, `prod_sat`=31.
  - a=-8, b=7 → `prod`=-56, `prod_sat`=-32.
  - a=3, b=-2 → `prod`=-6, `prod_sat`=-6.
- Arbitration:
  - All four `req` high from reset → grants in order 0,1,2,3, each spaced `W`+2 cycles, each deasserting after its grant.
  - Then `req[0]` and `req[3]` together → 0 wins (`ptr`=0). Repeat with `ptr`=1 → 3 wins.
- Pull `reset_n` low for one cycle, two cycles into RUN:
  - No `done` pulse.
  - All outputs read 0.
  - The next request to requester 2 is granted normally with correct result.
- Exhaustive check on requester 3: all 16×16 operand pairs in both `sgn` modes; `prod` and `prod_sat` must match the reference model every time.
- Ignored request: `req[1]` raised during RUN and dropped before IDLE → no grant issued to requester 1.
